// File: rtl/zueirai_mem.sv
// zueirai_mem: 1024x8 RAM with edge-triggered core writes, a program-load port
// that takes priority, and a sticky collision flag.
// With ZUEIRAI_MEM_IO_EN defined, page 3 addresses 0xF0-0xF8 map to I/O
// registers (DATA/DIR read-write, PIN read-only through a 2-flop synchronizer).
module zueirai_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] ctrl_MEM,
  input  logic [7:0]  in_MEM,
  output logic [7:0]  out_MEM,
  input  logic        prog_we,
  input  logic [9:0]  prog_addr,
  input  logic [7:0]  prog_data,
  output logic        err,
  output logic [7:0]  DATA_A,
  output logic [7:0]  DATA_B,
  output logic [7:0]  DATA_C,
  output logic [7:0]  DIR_A,
  output logic [7:0]  DIR_B,
  output logic [7:0]  DIR_C,
  input  logic [7:0]  PIN_A,
  input  logic [7:0]  PIN_B,
  input  logic [7:0]  PIN_C
);

  logic [7:0] r_mem [0:1023];
  logic       r_write_q;
  logic [7:0] r_out;
  logic       r_err;

  logic [9:0] w_addr;
  logic       w_load;
  logic       w_write;
  logic       w_wr_edge;
  logic       w_core_we;
  logic       w_core_io;
  logic       w_core_pin;
  logic       w_prog_io;
  logic       w_ram_we;
  logic [9:0] w_ram_addr;
  logic [7:0] w_ram_data;
  logic [7:0] w_io_rd;
  logic [7:0] w_rd_data;

  assign w_addr    = ctrl_MEM[9:0];
  assign w_load    = ctrl_MEM[10];
  assign w_write   = ctrl_MEM[11];
  assign w_wr_edge = w_write & ~r_write_q;
  // A program-load write always wins; the coinciding core write is dropped.
  assign w_core_we = w_wr_edge & ~prog_we;

`ifdef ZUEIRAI_MEM_IO_EN
  logic [7:0] r_data_a, r_data_b, r_data_c;
  logic [7:0] r_dir_a, r_dir_b, r_dir_c;
  logic [7:0] r_pin_a_s1, r_pin_b_s1, r_pin_c_s1;
  logic [7:0] r_pin_a_s2, r_pin_b_s2, r_pin_c_s2;

  function automatic logic io_hit(input logic [9:0] a);
    return (a[9:8] == 2'b11) && (a[7:0] >= 8'hF0) && (a[7:0] <= 8'hF8);
  endfunction

  function automatic logic pin_hit(input logic [9:0] a);
    return (a[9:8] == 2'b11) && (a[7:0] >= 8'hF6) && (a[7:0] <= 8'hF8);
  endfunction

  assign w_core_io  = io_hit(w_addr);
  assign w_core_pin = pin_hit(w_addr);
  assign w_prog_io  = io_hit(prog_addr);

  // I/O register read mux for mapped core addresses.
  always_comb begin
    w_io_rd = 8'h00;
    case (w_addr[7:0])
      8'hF0:   w_io_rd = r_data_a;
      8'hF1:   w_io_rd = r_data_b;
      8'hF2:   w_io_rd = r_data_c;
      8'hF3:   w_io_rd = r_dir_a;
      8'hF4:   w_io_rd = r_dir_b;
      8'hF5:   w_io_rd = r_dir_c;
      8'hF6:   w_io_rd = r_pin_a_s2;
      8'hF7:   w_io_rd = r_pin_b_s2;
      8'hF8:   w_io_rd = r_pin_c_s2;
      default: w_io_rd = 8'h00;
    endcase
  end

  // DATA/DIR registers; prog writes are applied last so they win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_a <= 8'h00; r_data_b <= 8'h00; r_data_c <= 8'h00;
      r_dir_a  <= 8'h00; r_dir_b  <= 8'h00; r_dir_c  <= 8'h00;
    end else begin
      if (w_core_we && w_core_io) begin
        case (w_addr[7:0])
          8'hF0:   r_data_a <= in_MEM;
          8'hF1:   r_data_b <= in_MEM;
          8'hF2:   r_data_c <= in_MEM;
          8'hF3:   r_dir_a  <= in_MEM;
          8'hF4:   r_dir_b  <= in_MEM;
          8'hF5:   r_dir_c  <= in_MEM;
          default: ;
        endcase
      end
      if (prog_we && w_prog_io) begin
        case (prog_addr[7:0])
          8'hF0:   r_data_a <= prog_data;
          8'hF1:   r_data_b <= prog_data;
          8'hF2:   r_data_c <= prog_data;
          8'hF3:   r_dir_a  <= prog_data;
          8'hF4:   r_dir_b  <= prog_data;
          8'hF5:   r_dir_c  <= prog_data;
          default: ;
        endcase
      end
    end
  end

  // Two-flop synchronizers for the asynchronous pin levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pin_a_s1 <= 8'h00; r_pin_b_s1 <= 8'h00; r_pin_c_s1 <= 8'h00;
      r_pin_a_s2 <= 8'h00; r_pin_b_s2 <= 8'h00; r_pin_c_s2 <= 8'h00;
    end else begin
      r_pin_a_s1 <= PIN_A;      r_pin_b_s1 <= PIN_B;      r_pin_c_s1 <= PIN_C;
      r_pin_a_s2 <= r_pin_a_s1; r_pin_b_s2 <= r_pin_b_s1; r_pin_c_s2 <= r_pin_c_s1;
    end
  end

  assign DATA_A = r_data_a;
  assign DATA_B = r_data_b;
  assign DATA_C = r_data_c;
  assign DIR_A  = r_dir_a;
  assign DIR_B  = r_dir_b;
  assign DIR_C  = r_dir_c;
`else
  logic w_unused_pins;

  assign w_core_io     = 1'b0;
  assign w_core_pin    = 1'b0;
  assign w_prog_io     = 1'b0;
  assign w_io_rd       = 8'h00;
  assign w_unused_pins = ^{PIN_A, PIN_B, PIN_C};
  assign DATA_A = 8'h00;
  assign DATA_B = 8'h00;
  assign DATA_C = 8'h00;
  assign DIR_A  = 8'h00;
  assign DIR_B  = 8'h00;
  assign DIR_C  = 8'h00;
`endif

  // Single RAM write port; no writes are accepted while reset is held.
  assign w_ram_we   = rst & (prog_we ? ~w_prog_io : (w_core_we & ~w_core_io));
  assign w_ram_addr = prog_we ? prog_addr : w_addr;
  assign w_ram_data = prog_we ? prog_data : in_MEM;

  // Read data with forwarding of a same-cycle prog write to the loaded address.
  always_comb begin
    w_rd_data = r_mem[w_addr];
    if (prog_we && (prog_addr == w_addr) && !w_core_pin)
      w_rd_data = prog_data;
    else if (w_core_io)
      w_rd_data = w_io_rd;
  end

  // RAM array; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_ram_we)
      r_mem[w_ram_addr] <= w_ram_data;
  end

  // Write-edge history, registered read data and the sticky collision flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write_q <= 1'b0;
      r_out     <= 8'h00;
      r_err     <= 1'b0;
    end else begin
      r_write_q <= w_write;
      if (w_wr_edge && prog_we)
        r_err <= 1'b1;
      if (w_load) begin
        if (w_core_we && !w_core_pin)
          r_out <= in_MEM;
        else
          r_out <= w_rd_data;
      end
    end
  end

  assign out_MEM = r_out;
  assign err     = r_err;

endmodule
